// File: rtl/smol_pkg.sv
// Shared definitions for the smol fetch stage: the fetch FSM states, the default reset PC
// and a small PC alignment helper.
package smol_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic pc_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/smol_fetch.sv
// Single-outstanding instruction fetch stage: request -> wait for response -> hold for decode.
// A misaligned next PC at accept parks the stage in a sticky fault state until reset.
module smol_fetch
    import smol_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_r, state_next_s;
    logic [31:0]  pc_r, pc_next_s;
    logic [31:0]  inst_r, inst_next_s;
    logic [31:0]  inst_pc_r, inst_pc_next_s;
    logic         fault_r, fault_next_s;
    logic [31:0]  fetch_count_r, fetch_count_next_s;

    // Next-state and datapath updates; responses only matter while waiting.
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        inst_next_s        = inst_r;
        inst_pc_next_s     = inst_pc_r;
        fault_next_s       = fault_r;
        fetch_count_next_s = fetch_count_r;
        case (state_r)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_next_s    = imem_rsp_data;
                    inst_pc_next_s = pc_r;
                    state_next_s   = S_HOLD;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    if (pc_aligned(next_pc[1:0])) begin
                        pc_next_s          = next_pc;
                        fetch_count_next_s = fetch_count_r + 32'd1;
                        state_next_s       = S_REQ;
                    end else begin
                        fault_next_s = 1'b1;
                        state_next_s = S_FAULT;
                    end
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            S_FAULT: begin
                state_next_s = S_FAULT;
            end
            default: begin
                fault_next_s = 1'b1;
                state_next_s = S_FAULT;
            end
        endcase
    end

    // State and datapath registers; reset wins over any same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_REQ;
            pc_r          <= RESET_PC;
            inst_r        <= 32'h0000_0000;
            inst_pc_r     <= 32'h0000_0000;
            fault_r       <= 1'b0;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            inst_r        <= inst_next_s;
            inst_pc_r     <= inst_pc_next_s;
            fault_r       <= fault_next_s;
            fetch_count_r <= fetch_count_next_s;
        end
    end

    assign imem_req_valid = (state_r == S_REQ);
    assign imem_req_addr  = pc_r;
    assign inst_valid     = (state_r == S_HOLD);
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign pc             = pc_r;
    assign fetch_fault    = fault_r;
    assign fetch_count    = fetch_count_r;

endmodule

// File: tb/tb_smol_fetch.sv
// Self-checking bench for smol_fetch: randomized fetch transactions checked against a
// transaction-level model (expected pc, count and fault tracked per accepted instruction).
module tb_smol_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int n_pass;
    int n_total;

    // Transaction-level reference state
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_fault;

    smol_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pc             (pc),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b0;
        step();
        rst = 1'b0;
        m_pc = 32'h0000_0000;
        m_count = 32'h0000_0000;
        m_fault = 1'b0;
    endtask

    // One full fetch transaction with configurable stalls; starts and ends at a negedge.
    task automatic fetch_one(input int req_stall, input int rsp_delay, input int hold_stall,
                             input logic [31:0] data, input logic [31:0] nxt);
        for (int i = 0; i < req_stall; i++) begin
            n_total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc)
                $display("FAIL req_stall valid=%0b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, m_pc);
            else n_pass++;
            imem_req_ready = 1'b0;
            imem_rsp_valid = $urandom_range(1, 0) == 1;
            imem_rsp_data = $urandom;
            step();
        end
        n_total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc)
            $display("FAIL req valid=%0b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, m_pc);
        else n_pass++;
        imem_req_ready = 1'b1;
        imem_rsp_valid = $urandom_range(1, 0) == 1;  // stray response during handshake
        imem_rsp_data = ~data;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            n_total++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
                $display("FAIL wait req_valid=%0b inst_valid=%0b expected 0 0", imem_req_valid, inst_valid);
            else n_pass++;
            imem_req_ready = $urandom_range(1, 0) == 1;
            step();
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = data;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        for (int i = 0; i < hold_stall; i++) begin
            n_total++;
            if (inst_valid !== 1'b1 || inst !== data || inst_pc !== m_pc || imem_req_valid !== 1'b0)
                $display("FAIL hold_stall valid=%0b inst=%h inst_pc=%h expected 1 %h %h", inst_valid, inst, inst_pc, data, m_pc);
            else n_pass++;
            inst_ready = 1'b0;
            next_pc = $urandom;
            imem_rsp_valid = $urandom_range(1, 0) == 1;
            step();
        end
        imem_rsp_valid = 1'b0;
        n_total++;
        if (inst_valid !== 1'b1 || inst !== data || inst_pc !== m_pc)
            $display("FAIL hold valid=%0b inst=%h inst_pc=%h expected 1 %h %h", inst_valid, inst, inst_pc, data, m_pc);
        else n_pass++;
        inst_ready = 1'b1;
        next_pc = nxt;
        step();
        inst_ready = 1'b0;
        if (nxt[1:0] == 2'b00) begin
            m_pc = nxt;
            m_count = m_count + 32'd1;
        end else begin
            m_fault = 1'b1;
        end
        n_total++;
        if (pc !== m_pc || fetch_count !== m_count || fetch_fault !== m_fault ||
            imem_req_valid !== !m_fault || inst_valid !== 1'b0)
            $display("FAIL accept pc=%h count=%h fault=%0b req=%0b iv=%0b expected %h %h %0b %0b 0",
                     pc, fetch_count, fetch_fault, imem_req_valid, inst_valid, m_pc, m_count, m_fault, !m_fault);
        else n_pass++;
    endtask

    task automatic test_reset();
        next_pc = $urandom;
        imem_rsp_data = $urandom;
        apply_reset();
        n_total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || pc !== 32'h0 || inst_valid !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || fetch_fault !== 1'b0 || fetch_count !== 32'h0)
            $display("FAIL reset req=%0b addr=%h pc=%h iv=%0b inst=%h ipc=%h fault=%0b count=%h expected 1 0 0 0 0 0 0 0",
                     imem_req_valid, imem_req_addr, pc, inst_valid, inst, inst_pc, fetch_fault, fetch_count);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        time t_prev;
        apply_reset();
        t_prev = $time;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                n_total++;
                if ($time - t_prev !== 30)
                    $display("FAIL request_spacing got %0t expected 30", $time - t_prev);
                else n_pass++;
            end
            t_prev = $time;
            fetch_one(0, 0, 0, $urandom, m_pc + 32'd4);
        end
        n_total++;
        if (fetch_count !== 32'd3 || imem_req_addr !== 32'hC)
            $display("FAIL zero_wait_end count=%h addr=%h expected 3 0000000c", fetch_count, imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_stalls();
        apply_reset();
        fetch_one(4, 0, 0, $urandom, 32'h10);
        fetch_one(0, 2, 5, 32'hDEAD_BEEF, 32'h100);
        n_total++;
        if (imem_req_addr !== 32'h100)
            $display("FAIL stall_redirect addr=%h expected 00000100", imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 20; k++)
            fetch_one($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                      $urandom, {$urandom} & 32'hFFFF_FFFC);
    endtask

    task automatic test_fault();
        logic [31:0] pc_before;
        apply_reset();
        fetch_one(0, 0, 0, $urandom, 32'h40);
        pc_before = m_pc;
        fetch_one(0, 0, 0, $urandom, 32'h102);
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            inst_ready = 1'b1;
            next_pc = 32'h200;
            step();
            n_total++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_fault !== 1'b1 || pc !== pc_before)
                $display("FAIL fault_hold req=%0b iv=%0b fault=%0b pc=%h expected 0 0 1 %h",
                         imem_req_valid, inst_valid, fetch_fault, pc, pc_before);
            else n_pass++;
        end
        apply_reset();
        n_total++;
        if (pc !== 32'h0 || fetch_fault !== 1'b0 || imem_req_valid !== 1'b1)
            $display("FAIL fault_clear pc=%h fault=%0b req=%0b expected 0 0 1", pc, fetch_fault, imem_req_valid);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        apply_reset();
        fetch_one(0, 0, 0, $urandom, 32'h80);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h1234_5678;
        step();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0)
                $display("FAIL late_rsp req=%0b addr=%h iv=%0b inst=%h expected 1 0 0 0",
                         imem_req_valid, imem_req_addr, inst_valid, inst);
            else n_pass++;
            step();
        end
        m_pc = 32'h0;
        m_count = 32'h0;
        fetch_one(0, 0, 0, 32'hCAFE_F00D, 32'h4);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b1;
        next_pc = 32'h300;
        rst = 1'b1;
        step();
        rst = 1'b0;
        inst_ready = 1'b0;
        n_total++;
        if (pc !== 32'h0 || fetch_count !== 32'h0 || imem_req_valid !== 1'b1 || inst_valid !== 1'b0)
            $display("FAIL rst_over_accept pc=%h count=%h req=%0b iv=%0b expected 0 0 1 0",
                     pc, fetch_count, imem_req_valid, inst_valid);
        else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        fetch_one(0, 0, 0, $urandom, 32'h20);
        dut.fetch_count_r = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        fetch_one(0, 1, 0, $urandom, 32'h24);
        n_total++;
        if (fetch_count !== 32'h0 || pc !== 32'h24 || fetch_fault !== 1'b0)
            $display("FAIL wrap count=%h pc=%h fault=%0b expected 0 00000024 0", fetch_count, pc, fetch_fault);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b0;
        next_pc = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        inst_ready = 1'b0;
        step();
        test_reset();
        test_zero_wait();
        test_stalls();
        test_random();
        test_fault();
        test_reset_priority();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
